// File: rtl/matmul2x2_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matmul2x2_arbiter_if
// Purpose  : Requester and engine handshake bundle for the 2x2 matmul arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface matmul2x2_arbiter_if;
  logic         rq0_Stable;
  logic [127:0] rq0_A;
  logic [127:0] rq0_B;
  logic         rq0_AB_Ack;
  logic [127:0] rq0_C;
  logic         rq0_C_Stable;
  logic         rq0_C_Ack;

  logic         rq1_Stable;
  logic [127:0] rq1_A;
  logic [127:0] rq1_B;
  logic         rq1_AB_Ack;
  logic [127:0] rq1_C;
  logic         rq1_C_Stable;
  logic         rq1_C_Ack;

  logic [127:0] eng_A;
  logic [127:0] eng_B;
  logic         eng_Stable;
  logic [127:0] eng_C;
  logic         eng_Done;
  logic         eng_C_Ack;

  logic         busy;
  logic         grant;
  logic         err;

  // Arbiter side
  modport master (
    input  rq0_Stable, rq0_A, rq0_B, rq0_C_Ack,
    input  rq1_Stable, rq1_A, rq1_B, rq1_C_Ack,
    input  eng_C, eng_Done,
    output rq0_AB_Ack, rq0_C, rq0_C_Stable,
    output rq1_AB_Ack, rq1_C, rq1_C_Stable,
    output eng_A, eng_B, eng_Stable, eng_C_Ack,
    output busy, grant, err
  );

  // Client and engine side
  modport slave (
    output rq0_Stable, rq0_A, rq0_B, rq0_C_Ack,
    output rq1_Stable, rq1_A, rq1_B, rq1_C_Ack,
    output eng_C, eng_Done,
    input  rq0_AB_Ack, rq0_C, rq0_C_Stable,
    input  rq1_AB_Ack, rq1_C, rq1_C_Stable,
    input  eng_A, eng_B, eng_Stable, eng_C_Ack,
    input  busy, grant, err
  );
endinterface
`default_nettype wire

// File: rtl/matmul2x2_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matmul2x2_arbiter
// Purpose  : Round-robin sharing of one 2x2 matmul engine between two requesters.
// Revision : 1.0 - initial release
// ============================================================================
module matmul2x2_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                  input_Clk,
  input  logic                  input_Reset,
  matmul2x2_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  localparam logic [TW-1:0] c_timeout_last = TW'(TIMEOUT - 1);

  state_t       r_state,        w_state;
  logic         r_last,         w_last;
  logic [TW-1:0] r_timer,       w_timer;
  logic         r_grant,        w_grant;
  logic         r_busy,         w_busy;
  logic         r_err,          w_err;
  logic         r_eng_stable,   w_eng_stable;
  logic         r_eng_c_ack,    w_eng_c_ack;
  logic [127:0] r_eng_a,        w_eng_a;
  logic [127:0] r_eng_b,        w_eng_b;
  logic         r_rq0_ab_ack,   w_rq0_ab_ack;
  logic         r_rq1_ab_ack,   w_rq1_ab_ack;
  logic [127:0] r_rq0_c,        w_rq0_c;
  logic [127:0] r_rq1_c,        w_rq1_c;
  logic         r_rq0_c_stable, w_rq0_c_stable;
  logic         r_rq1_c_stable, w_rq1_c_stable;

  logic         w_sel;
  logic         w_own_c_ack;
  logic         w_timeout;
  logic         w_abort;

  always_comb begin
    w_state        = r_state;
    w_last         = r_last;
    w_timer        = r_timer;
    w_grant        = r_grant;
    w_busy         = r_busy;
    w_err          = r_err;
    w_eng_stable   = r_eng_stable;
    w_eng_c_ack    = r_eng_c_ack;
    w_eng_a        = r_eng_a;
    w_eng_b        = r_eng_b;
    w_rq0_ab_ack   = 1'b0;
    w_rq1_ab_ack   = 1'b0;
    w_rq0_c        = r_rq0_c;
    w_rq1_c        = r_rq1_c;
    w_rq0_c_stable = r_rq0_c_stable;
    w_rq1_c_stable = r_rq1_c_stable;
    w_abort        = 1'b0;

    // Contention goes to whoever was not served last
    w_sel       = (bus.rq0_Stable && bus.rq1_Stable) ? ~r_last : bus.rq1_Stable;
    w_own_c_ack = r_grant ? bus.rq1_C_Ack : bus.rq0_C_Ack;
    w_timeout   = (r_timer == c_timeout_last);

    case (r_state)
      ST_IDLE: begin
        if (bus.rq0_Stable || bus.rq1_Stable) begin
          w_eng_a      = w_sel ? bus.rq1_A : bus.rq0_A;
          w_eng_b      = w_sel ? bus.rq1_B : bus.rq0_B;
          w_rq0_ab_ack = ~w_sel;
          w_rq1_ab_ack = w_sel;
          w_eng_stable = 1'b1;
          w_grant      = w_sel;
          w_busy       = 1'b1;
          w_timer      = '0;
          w_state      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        w_timer = r_timer + TW'(1);
        if (bus.eng_Done) begin
          if (r_grant) begin
            w_rq1_c = bus.eng_C;
          end else begin
            w_rq0_c = bus.eng_C;
          end
          w_eng_stable = 1'b0;
          w_eng_c_ack  = 1'b1;
          w_timer      = '0;
          w_state      = ST_RELEASE;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end

      ST_RELEASE: begin
        w_timer = r_timer + TW'(1);
        if (!bus.eng_Done) begin
          w_eng_c_ack = 1'b0;
          if (r_grant) begin
            w_rq1_c_stable = 1'b1;
          end else begin
            w_rq0_c_stable = 1'b1;
          end
          w_state = ST_DELIVER;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end

      ST_DELIVER: begin
        if (w_own_c_ack) begin
          w_rq0_c_stable = 1'b0;
          w_rq1_c_stable = 1'b0;
          w_last         = r_grant;
          w_busy         = 1'b0;
          w_state        = ST_IDLE;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // A stuck engine still yields a (zeroed) result so the client never hangs
    if (w_abort) begin
      w_err        = 1'b1;
      w_eng_stable = 1'b0;
      w_eng_c_ack  = 1'b0;
      w_timer      = '0;
      if (r_grant) begin
        w_rq1_c        = '0;
        w_rq1_c_stable = 1'b1;
      end else begin
        w_rq0_c        = '0;
        w_rq0_c_stable = 1'b1;
      end
      w_state = ST_DELIVER;
    end
  end

  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      r_state        <= ST_IDLE;
      r_last         <= 1'b1;
      r_timer        <= '0;
      r_grant        <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
      r_eng_stable   <= 1'b0;
      r_eng_c_ack    <= 1'b0;
      r_eng_a        <= '0;
      r_eng_b        <= '0;
      r_rq0_ab_ack   <= 1'b0;
      r_rq1_ab_ack   <= 1'b0;
      r_rq0_c        <= '0;
      r_rq1_c        <= '0;
      r_rq0_c_stable <= 1'b0;
      r_rq1_c_stable <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_last         <= w_last;
      r_timer        <= w_timer;
      r_grant        <= w_grant;
      r_busy         <= w_busy;
      r_err          <= w_err;
      r_eng_stable   <= w_eng_stable;
      r_eng_c_ack    <= w_eng_c_ack;
      r_eng_a        <= w_eng_a;
      r_eng_b        <= w_eng_b;
      r_rq0_ab_ack   <= w_rq0_ab_ack;
      r_rq1_ab_ack   <= w_rq1_ab_ack;
      r_rq0_c        <= w_rq0_c;
      r_rq1_c        <= w_rq1_c;
      r_rq0_c_stable <= w_rq0_c_stable;
      r_rq1_c_stable <= w_rq1_c_stable;
    end
  end

  assign bus.rq0_AB_Ack   = r_rq0_ab_ack;
  assign bus.rq0_C        = r_rq0_c;
  assign bus.rq0_C_Stable = r_rq0_c_stable;
  assign bus.rq1_AB_Ack   = r_rq1_ab_ack;
  assign bus.rq1_C        = r_rq1_c;
  assign bus.rq1_C_Stable = r_rq1_c_stable;
  assign bus.eng_A        = r_eng_a;
  assign bus.eng_B        = r_eng_b;
  assign bus.eng_Stable   = r_eng_stable;
  assign bus.eng_C_Ack    = r_eng_c_ack;
  assign bus.busy         = r_busy;
  assign bus.grant        = r_grant;
  assign bus.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matmul2x2_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matmul2x2_arbiter
// Purpose  : Scoreboard bench for matmul2x2_arbiter with a behavioural engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul2x2_arbiter;

  localparam int           TIMEOUT = 16;
  localparam int           ENG_LAT = 10;
  localparam logic [127:0] IDENT   = {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
  localparam logic [127:0] BMAT    = {32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  localparam logic [127:0] SALT    = {4{32'hA5C30F1E}};

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_miss;
  bit   eng_hang;
  int   e_st;
  int   e_cnt;

  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];
  int           grant_log[$];
  int           grant_cyc[2];
  int           stable_cyc[2];
  int           cack_cyc[2];

  matmul2x2_arbiter_if bus ();

  matmul2x2_arbiter #(
    .TIMEOUT (TIMEOUT),
    .TW      (5)
  ) dut (
    .input_Clk   (clk),
    .input_Reset (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine stand-in: exact for an identity A, otherwise a digest that exposes misrouting
  function automatic logic [127:0] eng_fn(input logic [127:0] a, input logic [127:0] b);
    if (a == IDENT) return b;
    return a ^ {b[63:0], b[127:64]} ^ SALT;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_st         <= 0;
      e_cnt        <= 0;
      bus.eng_Done <= 1'b0;
      bus.eng_C    <= '0;
    end else begin
      case (e_st)
        0: if (bus.eng_Stable && !eng_hang) begin
          e_cnt <= 1;
          e_st  <= 1;
        end
        1: if (e_cnt == ENG_LAT - 1) begin
          bus.eng_Done <= 1'b1;
          bus.eng_C    <= eng_fn(bus.eng_A, bus.eng_B);
          e_st         <= 2;
        end else begin
          e_cnt <= e_cnt + 1;
        end
        2: if (bus.eng_C_Ack) begin
          bus.eng_Done <= 1'b0;
          e_st         <= 3;
        end
        default: if (!bus.eng_C_Ack) e_st <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rq0_AB_Ack) grant_log.push_back(0);
      if (bus.rq1_AB_Ack) grant_log.push_back(1);
    end
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_req(input int r, input logic stb, input logic [127:0] a, input logic [127:0] b);
    if (r == 1) begin
      bus.rq1_Stable = stb; bus.rq1_A = a; bus.rq1_B = b;
    end else begin
      bus.rq0_Stable = stb; bus.rq0_A = a; bus.rq0_B = b;
    end
  endtask

  task automatic set_c_ack(input int r, input logic v);
    if (r == 1) bus.rq1_C_Ack = v;
    else        bus.rq0_C_Ack = v;
  endtask

  function automatic logic get_ab_ack(input int r);
    return (r == 1) ? bus.rq1_AB_Ack : bus.rq0_AB_Ack;
  endfunction

  function automatic logic get_c_stable(input int r);
    return (r == 1) ? bus.rq1_C_Stable : bus.rq0_C_Stable;
  endfunction

  function automatic logic [127:0] get_c(input int r);
    return (r == 1) ? bus.rq1_C : bus.rq0_C;
  endfunction

  // One full client transaction: request, wait grant, wait result, acknowledge
  task automatic req(input int r, input logic [127:0] a, input logic [127:0] b, input int ack_dly);
    logic [127:0] exp_c;
    logic [127:0] held;
    bit           ok;
    exp_c = eng_hang ? '0 : eng_fn(a, b);
    if (r == 1) exp_q1.push_back(exp_c);
    else        exp_q0.push_back(exp_c);
    @(negedge clk);
    set_req(r, 1'b1, a, b);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (get_ab_ack(r)) begin ok = 1'b1; break; end
    end
    check($sformatf("ab_ack_seen_rq%0d", r), ok, 1);
    set_req(r, 1'b0, a, b);
    if (!ok) return;
    grant_cyc[r] = cyc;
    check("grant_idx", bus.grant, r);
    check("eng_A", bus.eng_A, a);
    check("eng_B", bus.eng_B, b);
    check("grant_ctl", {bus.eng_Stable, bus.busy}, 2'b11);
    @(negedge clk);
    check("ab_ack_pulse", get_ab_ack(r), 0);
    ok = get_c_stable(r);
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = get_c_stable(r);
    end
    check($sformatf("c_stable_seen_rq%0d", r), ok, 1);
    if (!ok) return;
    stable_cyc[r] = cyc;
    if (r == 1 && exp_q1.size() > 0)      check("c_rq1", bus.rq1_C, exp_q1.pop_front());
    else if (r == 0 && exp_q0.size() > 0) check("c_rq0", bus.rq0_C, exp_q0.pop_front());
    else                                  check("scoreboard_empty", 1, 0);
    check("deliver_eng_idle", {bus.eng_Stable, bus.eng_C_Ack}, 2'b00);
    held = get_c(r);
    if (ack_dly > 0) begin
      repeat (ack_dly) @(negedge clk);
      check("c_held", get_c(r), held);
      check("late_ack_ctl", {get_c_stable(r), bus.busy}, 2'b11);
    end
    set_c_ack(r, 1'b1);
    cack_cyc[r] = cyc + 1;
    @(negedge clk);
    set_c_ack(r, 1'b0);
    check("c_stable_clear", {get_c_stable(r), bus.busy}, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_c"}, bus.rq0_C | bus.rq1_C, '0);
    check({tag, "_eng"}, bus.eng_A | bus.eng_B, '0);
    check({tag, "_ctl"}, {bus.rq0_AB_Ack, bus.rq0_C_Stable, bus.rq1_AB_Ack, bus.rq1_C_Stable,
                          bus.eng_Stable, bus.eng_C_Ack, bus.busy, bus.grant, bus.err}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    bit           ok;
    n_vec    = 0;
    n_miss   = 0;
    cyc      = 0;
    eng_hang = 1'b0;
    rst_n    = 1'b0;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    set_c_ack(0, 1'b0);
    set_c_ack(1, 1'b0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single request through the identity
    grant_log.delete();
    req(0, IDENT, BMAT, 0);
    check("single_c_is_B", bus.rq0_C, BMAT);
    check("single_latency", stable_cyc[0] - grant_cyc[0], ENG_LAT + 3);
    check("single_rq1_quiet", {bus.rq1_C, bus.rq1_C_Stable}, '0);
    check("single_err", bus.err, 0);
    check("single_grants", grant_log.size(), 1);

    // Simultaneous requests straight after reset
    do_reset();
    grant_log.delete();
    fork
      req(0, rnd128(), rnd128(), 0);
      req(1, rnd128(), rnd128(), 0);
    join
    check("sim_grant_count", grant_log.size(), 2);
    for (int i = 0; i < 2 && i < grant_log.size(); i++) check("sim_grant_order", grant_log[i], i);
    check("b2b_gap", grant_cyc[1], cack_cyc[0] + 1);

    // Saturation fairness
    grant_log.delete();
    fork
      begin for (int i = 0; i < 3; i++) req(0, rnd128(), rnd128(), 0); end
      begin for (int j = 0; j < 3; j++) req(1, rnd128(), rnd128(), 0); end
    join
    check("sat_grant_count", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++) check("sat_grant_order", grant_log[i], i % 2);

    // Engine hang and watchdog abort
    eng_hang = 1'b1;
    req(0, rnd128(), rnd128(), 0);
    check("hang_latency", stable_cyc[0] - grant_cyc[0], TIMEOUT);
    check("hang_err", bus.err, 1);
    eng_hang = 1'b0;
    req(1, rnd128(), rnd128(), 0);
    check("hang_err_sticky", bus.err, 1);

    // Late acknowledge from rq1 while rq0 waits
    fork
      req(1, rnd128(), rnd128(), 50);
      begin repeat (3) @(negedge clk); req(0, rnd128(), rnd128(), 0); end
    join
    check("late_ack_order", grant_cyc[0], cack_cyc[1] + 1);

    // Reset while the engine is being released
    a = rnd128();
    b = rnd128();
    @(negedge clk);
    set_req(1, 1'b1, a, b);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.rq1_AB_Ack) begin ok = 1'b1; break; end
    end
    set_req(1, 1'b0, a, b);
    for (int n = 0; n < 400 && ok && !bus.eng_C_Ack; n++) @(negedge clk);
    check("release_reached", ok && bus.eng_C_Ack, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    req(1, rnd128(), rnd128(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
